// File: rtl/hp_fifo_r3.sv
// hp_fifo_r3 -- host-to-parasite Tube register 3 data path.
//
// A two-entry byte FIFO. v_mode selects a depth of 1 byte (v_mode=0) or
// 2 bytes (v_mode=1). The host sees "not full", the parasite sees
// "data available" and an optional NMI request. Host writes that cannot
// be accepted are dropped and recorded in a sticky overrun flag.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   h_we, h_wdata    host write strobe and data
//   p_re             parasite read strobe
//   p_rdata          head-of-FIFO byte
//   v_mode           depth select (0: 1 byte, 1: 2 bytes)
//   m_nmi_en         enables p_nmi
//   flush            synchronous clear, same effect as rst
//   h_not_full       host status: a byte can be accepted
//   p_data_available parasite status: data ready to read
//   p_nmi            NMI request to the parasite
//   h_overrun        sticky: a host write was dropped
module hp_fifo_r3 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          h_we,
    input  logic [DW-1:0] h_wdata,
    input  logic          p_re,
    output logic [DW-1:0] p_rdata,
    input  logic          v_mode,
    input  logic          m_nmi_en,
    input  logic          flush,
    output logic          h_not_full,
    output logic          p_data_available,
    output logic          p_nmi,
    output logic          h_overrun
);

    logic [DW-1:0] mem [0:1];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          avail;
    logic          overrun;

    logic [1:0]    depth;
    logic          rd_ok;
    logic          wr_ok;
    logic [1:0]    count_next;
    logic          avail_next;
    logic          overrun_next;
    logic          clear;

    assign clear = rst | flush;

    always_comb begin
        depth        = v_mode ? 2'd2 : 2'd1;
        rd_ok        = p_re && (count != 2'd0);
        // A same-cycle read frees a slot, so a write is accepted even at
        // full depth (or above it, after v_mode dropped to 0).
        wr_ok        = h_we && ((count < depth) || rd_ok);
        count_next   = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + 2'd1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - 2'd1;
        end
        // avail only changes at the extremes; in 2-byte mode a single
        // byte neither raises nor lowers it.
        avail_next   = avail;
        if (count_next == depth) begin
            avail_next = 1'b1;
        end else if (count_next == 2'd0) begin
            avail_next = 1'b0;
        end
        overrun_next = overrun | (h_we & ~wr_ok);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            count            <= '0;
            avail            <= 1'b0;
            overrun          <= 1'b0;
            h_not_full       <= 1'b1;
            p_data_available <= 1'b0;
            p_nmi            <= 1'b0;
            h_overrun        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count            <= count_next;
            avail            <= avail_next;
            overrun          <= overrun_next;
            h_not_full       <= (count_next < depth);
            p_data_available <= avail_next;
            p_nmi            <= m_nmi_en & avail_next;
            h_overrun        <= overrun_next;
        end
    end

    // Storage is not cleared; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (!clear && wr_ok) begin
            mem[wr_ptr] <= h_wdata;
        end
    end

    assign p_rdata = mem[rd_ptr];

endmodule

// File: doc/hp_fifo_r3.md
Name: hp_fifo_r3

Overview:
- Host-to-parasite data path for Tube register 3: a 2-entry byte FIFO with host-side "not full" status, parasite-side "data available" status and a parasite NMI request.
- Depth is 1 byte when v_mode=0 and 2 bytes when v_mode=1.
- The block is fully synchronous on one clock. It sits beside the parasite-to-host register 3 flag logic in the Tube ULA, and the host/parasite bus decoders drive it with single-cycle strobes.

Parameters:
- DW, 8, data width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- h_we  in  1  host write strobe, one clk cycle per host write to R3.
- h_wdata  in  DW  host write data, sampled when h_we=1.
- p_re  in  1  parasite read strobe, one clk cycle per parasite read of R3.
- p_rdata  out  DW  head-of-FIFO byte.
- v_mode  in  1  Tube V flag; 0 = 1-byte mode, 1 = 2-byte mode.
- m_nmi_en  in  1  Tube M flag; enables p_nmi.
- flush  in  1  synchronous clear from the host control register (Tube S/T clear).
- h_not_full  out  1  host status: the FIFO can accept a byte.
- p_data_available  out  1  parasite status: data is ready to read.
- p_nmi  out  1  NMI request to the parasite.
- h_overrun  out  1  sticky flag: a host write was dropped.

Behaviour:
- State:
  - mem[0:1] of DW bits.
  - wr_ptr and rd_ptr, 1 bit each.
  - count, 2 bits, range 0..2.
  - avail latch.
  - overrun latch.
- depth = 1 + v_mode.
- Reset (rst=1), and flush=1 (flush has equal priority):
  - count=0, wr_ptr=0, rd_ptr=0, avail=0, overrun=0.
  - h_not_full=1, p_data_available=0, p_nmi=0, h_overrun=0.
  - mem contents are don't-care; p_rdata=mem[0].
  - rst/flush overrides any strobe in the same cycle.
- Write accept:
  - Condition: h_we=1 and (count < depth, or p_re=1 with count>0 in the same cycle).
  - Action: mem[wr_ptr] <= h_wdata; wr_ptr toggles.
- Write drop:
  - Condition: h_we=1 and not accepted.
  - Action: no state change except overrun <= 1.
  - overrun stays set until rst or flush.
- Read:
  - Condition: p_re=1 and count>0.
  - Action: rd_ptr toggles.
  - p_re=1 with count=0 is ignored; nothing changes.
- Count update:
  - +1 for accept only, −1 for read only.
  - Unchanged when an accept and a read happen in the same cycle.
  - Simultaneous read and write when count=depth is accepted; count stays at depth.
- p_rdata = mem[rd_ptr], combinational from registered state.
  - Valid while p_data_available=1.
  - The cycle after a read strobe shows the next entry.
- avail latch (uses next-state count, count'):
  - Set when count' == depth'.
  - Cleared when count' == 0.
  - Otherwise held.
  - Effect in 2-byte mode: the parasite sees data only after both bytes arrive, and the flag stays high until both bytes are read.
- Registered outputs, all from next-state values, so they are valid in the cycle after the causing strobe:
  - h_not_full = (count' < depth').
  - p_data_available = avail'.
  - p_nmi = m_nmi_en & avail'.
  - h_overrun = overrun'.
- m_nmi_en changes take effect on p_nmi on the next edge.
- v_mode changing while count > new depth (count=2 → v_mode=0):
  - No data is discarded.
  - h_not_full stays 0 until count < depth.
  - avail is held.
- Pointer wrap: 1-bit pointers wrap naturally. count never exceeds 2, and no accept occurs when count=2 without a same-cycle read.

Test Plan:
1. Reset then v_mode=0. Expect h_not_full=1, p_data_available=0, p_nmi=0, h_overrun=0. Then write 0x5A with m_nmi_en=1. Expect next cycle: h_not_full=0, p_data_available=1, p_nmi=1, p_rdata=0x5A. Then read. Expect next cycle: h_not_full=1, p_data_available=0, p_nmi=0.
2. v_mode=1, write 0x11. Expect p_data_available=0, h_not_full=1. Write 0x22. Expect p_data_available=1, h_not_full=0, p_rdata=0x11. Read. Expect p_rdata=0x22, p_data_available=1, h_not_full=1. Read. Expect p_data_available=0.
3. v_mode=0, FIFO holds 0x33. Write 0x44. Expect p_rdata still 0x33 and h_overrun=1. Read. Expect p_rdata=mem head unchanged at 0x33 position consumed, count=0. Then flush. Expect h_overrun=0.
4. v_mode=1, count=2 holding 0xA1, 0xA2. Issue h_we (0xA3) and p_re in the same cycle. Expect count=2, p_rdata=0xA2, then after the next read p_rdata=0xA3, with no overrun.
5. p_re while empty. Expect no change and no underflow: count stays 0, p_data_available=0. Then assert rst in the same cycle as h_we=1. Expect h_not_full=1, p_data_available=0, and the write discarded.
6. v_mode=1 with 2 bytes held, switch v_mode to 0. Expect h_not_full=0 and p_data_available=1. Read once. Expect h_not_full=0 (count=1=depth). Read again. Expect h_not_full=1 and p_data_available=0.
